// File: rtl/fifo_rd_stream_if.sv
// Read-side stream bundle: FIFO pop port plus the valid/ready stream it feeds.
// The master modport is the adapter; the slave modport is the FIFO plus the downstream consumer.
interface fifo_rd_stream_if #(
   parameter int DATA_WIDTH = 32,
   parameter int CNT_WIDTH  = 2
);
   logic                  o_fifo_rd_en;
   logic                  i_fifo_rd_empty;
   logic [DATA_WIDTH-1:0] i_fifo_rd_data;
   logic                  o_valid;
   logic                  i_ready;
   logic [DATA_WIDTH-1:0] o_data;
   logic [CNT_WIDTH-1:0]  o_level;

   modport master (
      output o_fifo_rd_en,
      input  i_fifo_rd_empty,
      input  i_fifo_rd_data,
      output o_valid,
      input  i_ready,
      output o_data,
      output o_level
   );

   modport slave (
      input  o_fifo_rd_en,
      output i_fifo_rd_empty,
      output i_fifo_rd_data,
      input  o_valid,
      output i_ready,
      input  o_data,
      input  o_level
   );
endinterface

// File: rtl/fifo_rd_stream.sv
// Turns the FIFO pop port (rd_en/empty, data one cycle later) into a valid/ready stream.
// A small prefetch buffer absorbs the read latency so a word can leave every cycle.
module fifo_rd_stream #(
   parameter int DATA_WIDTH = 32,
   parameter int BUF_DEPTH  = 2,
   parameter int ADDR_WIDTH = $clog2(BUF_DEPTH),
   parameter int CNT_WIDTH  = $clog2(BUF_DEPTH + 1)
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_flush,
   fifo_rd_stream_if.master bus
);

   logic [DATA_WIDTH-1:0] buf_q [BUF_DEPTH];
   logic [DATA_WIDTH-1:0] buf_d [BUF_DEPTH];
   logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
   logic                  inflight_q, inflight_d;
   logic                  pop;
   logic                  push;
   logic                  rd_en;
   logic [CNT_WIDTH:0]    committed;

   always_comb begin
      pop  = (cnt_q != '0) && bus.i_ready;
      push = inflight_q && !i_flush;

      // Slots already spoken for after this cycle: held words plus the read in flight,
      // minus the word leaving now. Using the pop here lets i_ready keep the FIFO at full rate.
      committed = {1'b0, cnt_q} + (CNT_WIDTH+1)'(inflight_q) - (CNT_WIDTH+1)'(pop);
      rd_en     = !i_rst && !i_flush && !bus.i_fifo_rd_empty
                  && (committed < (CNT_WIDTH+1)'(BUF_DEPTH));

      buf_d      = buf_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      cnt_d      = cnt_q + CNT_WIDTH'(push) - CNT_WIDTH'(pop);
      inflight_d = rd_en;

      if (push) begin
         buf_d[wr_ptr_q] = bus.i_fifo_rd_data;
         wr_ptr_d        = wr_ptr_q + ADDR_WIDTH'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
      end

      // Flush drops buffered words and the word still coming out of the FIFO.
      if (i_flush) begin
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         cnt_d      = '0;
         inflight_d = 1'b0;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         for (int i = 0; i < BUF_DEPTH; i++) begin
            buf_q[i] <= '0;
         end
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         cnt_q      <= '0;
         inflight_q <= 1'b0;
      end else begin
         buf_q      <= buf_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         cnt_q      <= cnt_d;
         inflight_q <= inflight_d;
      end
   end

   assign bus.o_fifo_rd_en = rd_en;
   assign bus.o_valid      = (cnt_q != '0);
   assign bus.o_data       = buf_q[rd_ptr_q];
   assign bus.o_level      = cnt_q;

endmodule
